// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters.
// One operation in flight; result returned on a tagged response port.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for a request; grant logic active
// ST_EXEC   | operands latched, ALU result registered at end of cycle
// ST_RESP   | rsp_valid high, holding result until rsp_ready
module alu_arbiter #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]   state;
    logic         last_id;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [2:0]   op_q;
    logic         id_q;
    logic         grant0;
    logic         grant1;
    logic [W-1:0] alu_y;

    // last_id resets to 1 so requester 0 wins the first tie
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_id);
        grant1 = req1_valid && (!req0_valid || !last_id);
    end

    assign req0_ready = (state == ST_IDLE) && grant0;
    assign req1_ready = (state == ST_IDLE) && grant1;

    always_comb begin
        alu_y = a_q;
        case (op_q)
            3'b001:  alu_y = a_q + b_q;
            3'b010:  alu_y = a_q - b_q;
            3'b011:  alu_y = a_q & b_q;
            3'b100:  alu_y = a_q | b_q;
            3'b101:  alu_y = a_q ^ b_q;
            default: alu_y = a_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            last_id   <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            id_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
            op_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        a_q     <= req1_ready ? req1_a : req0_a;
                        b_q     <= req1_ready ? req1_b : req0_b;
                        op_q    <= req1_ready ? req1_op : req0_op;
                        id_q    <= req1_ready;
                        last_id <= req1_ready;
                        state   <= ST_EXEC;
                        busy    <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    rsp_data  <= alu_y;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_cnt    <= op_cnt + CNT_W'(1);
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
